parity_stream_gen: RTL and testbench
====================================

Name: parity_stream_gen

Overview:
- Parametrised streaming parity generator/checker; successor to the fixed 8-bit combinational even-parity generator.
- Accepts DATA_W-bit words over a valid/ready handshake and registers each word with its parity bit in one pipeline stage.
- Per-beat mode selects even or odd parity and generate-only or check.
- Sits between a word producer (UART/bus framer) and a consumer that needs the parity bit or a parity-error flag.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- CNT_W, 8, error counter width in bits (>=1); used only with PARITY_ERR_CNT_EN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  DATA_W  input word.
- in_par  in  1  received parity bit; compared only when in_chk=1.
- in_odd  in  1  per-beat mode: 0 = even parity, 1 = odd parity.
- in_chk  in  1  per-beat mode: 1 = check in_par, 0 = generate only.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_data  out  DATA_W  registered copy of in_data.
- out_par  out  1  generated parity bit.
- out_err  out  1  parity mismatch flag for this beat.
- err_cnt  out  CNT_W  saturating error count (PARITY_ERR_CNT_EN only).
- err_clr  in  1  synchronous counter clear (PARITY_ERR_CNT_EN only).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_par=0, out_err=0, err_cnt=0. in_ready reads 1 in the first cycle after reset.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, single-entry pipeline stage).
  - Input beat accepted when in_valid && in_ready. Output beat consumed when out_valid && out_ready.
- Latency: a beat accepted at edge N is presented at edge N with out_valid=1.
  - Full throughput of one beat per cycle while out_ready=1.
- Load on accept:
  - out_data <= in_data.
  - out_par <= (^in_data) ^ in_odd. Even mode makes the total ones count across data+parity even; odd mode makes it odd.
  - out_err <= in_chk && (in_par != ((^in_data) ^ in_odd)).
- Valid update:
  - Accept, with or without a simultaneous consume: out_valid <= 1.
  - Consume without accept: out_valid <= 0; out_data, out_par and out_err hold their values.
- Backpressure: while out_valid=1 && out_ready=0, all out_* signals are held stable and in_ready=0. Input signals are ignored.
- Mode sampling: in_odd and in_chk are sampled per beat only at accept. Mode changes never alter a beat already held.
- Generate-only beats (in_chk=0) always produce out_err=0.
- DATA_W=1: parity equals the data bit XOR in_odd.
- Reset mid-operation: rst wins over any handshake in the same cycle. A held beat is dropped and all outputs return to reset values.

Optional Feature:
- Macro: PARITY_ERR_CNT_EN.
- Defined: err_cnt and err_clr ports exist.
  - err_cnt increments by 1 on each accepted beat with a computed error.
  - Saturates at 2^CNT_W-1; no wrap.
  - err_clr=1 clears the count to 0. err_clr together with an erroring accept loads 1.
  - rst clears the count to 0.
- Not defined: err_cnt and err_clr ports and the counter logic are absent. Data path behaviour is identical in both builds.

Test Plan:
- DATA_W=8, even, generate, out_ready=1: stream 10101010, 11101010, 11111110, 00101010 -> out_par 0,1,1,1 one cycle after each accept; out_err=0; one beat per cycle.
- Odd mode (in_odd=1), in_data 10101010 and 10001010 -> out_par 1 then 0.
- Check mode, even, in_data 10111010 (5 ones): in_par=1 -> out_err=0; in_par=0 -> out_err=1. Same data with in_chk=0 and in_par=0 -> out_err=0.
- Backpressure: accept 10101011, hold out_ready=0 for 3 cycles while in_valid=1 with new data -> in_ready=0, outputs stable at data 10101011 / par 1. Raise out_ready -> next beat accepted the same cycle and presented at the following edge.
- Reset mid-stream: assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, out_par=0, out_err=0, in_ready=1.
- PARITY_ERR_CNT_EN, CNT_W=2: 5 erroring beats -> err_cnt 1,2,3,3,3. err_clr with a 6th erroring accept -> err_cnt=1. err_clr alone -> 0.

Source files
------------

// File: rtl/parity_stream_gen.sv
// Single-stage valid/ready parity generator/checker with per-beat even/odd and check modes.
// Optional saturating error counter enabled by defining PARITY_ERR_CNT_EN.
module parity_stream_gen #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_par,
    input  logic              in_odd,
    input  logic              in_chk,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_par,
    output logic              out_err
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]  err_cnt,
    input  logic              err_clr
`endif
);

    generate
        if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
            $error("parity_stream_gen: DATA_W and CNT_W must be at least 1");
        end
    endgenerate

    logic accept;
    logic consume;
    logic par_calc;
    logic err_calc;

    // The stage may take a new beat whenever it is empty or its beat leaves this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;
    assign par_calc = (^in_data) ^ in_odd;
    assign err_calc = in_chk && (in_par != par_calc);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_par   <= 1'b0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_par   <= par_calc;
            out_err   <= err_calc;
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

`ifdef PARITY_ERR_CNT_EN
    // A clear coinciding with an erroring accept counts that error, so the result is 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= (accept && err_calc) ? CNT_W'(1) : '0;
        end else if (accept && err_calc && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_parity_stream_gen.sv
// Scoreboard bench for parity_stream_gen; counter checks are built when PARITY_ERR_CNT_EN is defined.
module tb_parity_stream_gen;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_par;
    logic              in_odd;
    logic              in_chk;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_par;
    logic              out_err;
`ifdef PARITY_ERR_CNT_EN
    logic [CNT_W-1:0]  err_cnt;
    logic              err_clr;
    logic [CNT_W-1:0]  w1_err_cnt;
`endif

    logic w1_in_valid;
    logic w1_in_ready;
    logic w1_in_data;
    logic w1_in_odd;
    logic w1_out_valid;
    logic w1_out_data;
    logic w1_out_par;
    logic w1_out_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              par;
        logic              err;
    } beat_t;

    beat_t sb[$];
    logic  m_valid = 1'b0;
`ifdef PARITY_ERR_CNT_EN
    logic [CNT_W-1:0] m_cnt = '0;
`endif

    always #5 clk = ~clk;

    parity_stream_gen #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_par    (in_par),
        .in_odd    (in_odd),
        .in_chk    (in_chk),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_par   (out_par),
        .out_err   (out_err)
`ifdef PARITY_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt),
        .err_clr   (err_clr)
`endif
    );

    parity_stream_gen #(.DATA_W(1), .CNT_W(CNT_W)) dut_w1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w1_in_valid),
        .in_ready  (w1_in_ready),
        .in_data   (w1_in_data),
        .in_par    (1'b0),
        .in_odd    (w1_in_odd),
        .in_chk    (1'b0),
        .out_valid (w1_out_valid),
        .out_ready (1'b1),
        .out_data  (w1_out_data),
        .out_par   (w1_out_par),
        .out_err   (w1_out_err)
`ifdef PARITY_ERR_CNT_EN
        ,
        .err_cnt   (w1_err_cnt),
        .err_clr   (1'b0)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] data, input logic odd, input logic chk, input logic par);
        in_valid = 1'b1;
        in_data  = data;
        in_odd   = odd;
        in_chk   = chk;
        in_par   = par;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Reference model: builds expected beats from the inputs alone, parity by counting ones.
    always @(posedge clk) begin
        logic  acc;
        logic  p;
        beat_t b;
        acc = in_valid && (!m_valid || out_ready);
        p   = ($countones(in_data) % 2 == 1) ^ in_odd;
        if (rst) begin
            m_valid = 1'b0;
            sb.delete();
        end else if (acc) begin
            b.data = in_data;
            b.par  = p;
            b.err  = in_chk && (in_par != p);
            sb.push_back(b);
            m_valid = 1'b1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
`ifdef PARITY_ERR_CNT_EN
        if (rst)
            m_cnt = '0;
        else if (err_clr)
            m_cnt = (acc && in_chk && (in_par != p)) ? CNT_W'(1) : '0;
        else if (acc && in_chk && (in_par != p) && m_cnt != '1)
            m_cnt = m_cnt + CNT_W'(1);
`endif
    end

    // Compare the held beat every cycle; retire it from the scoreboard when it is consumed.
    always @(negedge clk) begin
        beat_t b;
        checkOutput("in_ready", in_ready, !m_valid || out_ready);
        checkOutput("out_valid", out_valid, m_valid);
`ifdef PARITY_ERR_CNT_EN
        checkOutput("err_cnt", err_cnt, m_cnt);
`endif
        if (out_valid) begin
            if (sb.size() == 0) begin
                checkOutput("sb_empty", 32'd0, 32'd1);
            end else begin
                b = sb[0];
                checkOutput("out_data", out_data, b.data);
                checkOutput("out_par", out_par, b.par);
                checkOutput("out_err", out_err, b.err);
                if (out_ready)
                    void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic [DATA_W-1:0] stream [4];
        logic              stream_par [4];
        stream     = '{8'b10101010, 8'b11101010, 8'b11111110, 8'b00101010};
        stream_par = '{1'b0, 1'b1, 1'b1, 1'b1};

        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_par = 1'b0; in_odd = 1'b0; in_chk = 1'b0;
        out_ready = 1'b1;
        w1_in_valid = 1'b0; w1_in_data = 1'b0; w1_in_odd = 1'b0;
`ifdef PARITY_ERR_CNT_EN
        err_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_par", out_par, 0);
        checkOutput("rst_out_err", out_err, 0);
        checkOutput("rst_in_ready", in_ready, 1);

        $display("[TB] even generate stream");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(stream[i], 1'b0, 1'b0, 1'b0);
            checkOutput("stream_par", out_par, stream_par[i]);
            checkOutput("stream_valid", out_valid, 1);
        end
        idleCycle();

        $display("[TB] odd mode");
        applyStimulus(8'b10101010, 1'b1, 1'b0, 1'b0);
        checkOutput("odd_par_a", out_par, 1);
        applyStimulus(8'b10001010, 1'b1, 1'b0, 1'b0);
        checkOutput("odd_par_b", out_par, 0);

        $display("[TB] check mode");
        applyStimulus(8'b10111010, 1'b0, 1'b1, 1'b1);
        checkOutput("chk_ok", out_err, 0);
        applyStimulus(8'b10111010, 1'b0, 1'b1, 1'b0);
        checkOutput("chk_bad", out_err, 1);
        applyStimulus(8'b10111010, 1'b0, 1'b0, 1'b0);
        checkOutput("gen_no_err", out_err, 0);
        idleCycle();

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(8'b10101011, 1'b0, 1'b0, 1'b0);
        in_data = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_in_ready", in_ready, 0);
            checkOutput("bp_data", out_data, 8'b10101011);
            checkOutput("bp_par", out_par, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_next_data", out_data, 8'h55);
        checkOutput("bp_next_valid", out_valid, 1);
        idleCycle();

        $display("[TB] reset mid-stream");
        out_ready = 1'b0;
        applyStimulus(8'h3C, 1'b0, 1'b1, 1'b1);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_data", out_data, 0);
        checkOutput("mid_rst_par", out_par, 0);
        checkOutput("mid_rst_err", out_err, 0);
        checkOutput("mid_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        idleCycle();

`ifdef PARITY_ERR_CNT_EN
        $display("[TB] error counter");
        begin
            logic [CNT_W-1:0] exp_cnt [5];
            exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
            for (int i = 0; i < 5; i++) begin
                applyStimulus(8'h01, 1'b0, 1'b1, 1'b0);
                checkOutput("cnt_sat", err_cnt, exp_cnt[i]);
            end
        end
        err_clr = 1'b1;
        applyStimulus(8'h01, 1'b0, 1'b1, 1'b0);
        checkOutput("cnt_clr_err", err_cnt, 1);
        idleCycle();
        checkOutput("cnt_clr_only", err_cnt, 0);
        err_clr = 1'b0;
        idleCycle();
`endif

        $display("[TB] DATA_W=1");
        for (int i = 0; i < 4; i++) begin
            w1_in_valid = 1'b1;
            w1_in_data  = i[0];
            w1_in_odd   = i[1];
            @(posedge clk);
            #1;
            checkOutput("w1_data", w1_out_data, i[0]);
            checkOutput("w1_par", w1_out_par, i[0] ^ i[1]);
            checkOutput("w1_err", w1_out_err, 0);
        end
        w1_in_valid = 1'b0;

        repeat (2) idleCycle();
        checkOutput("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
